// File: rtl/passive_security_ctrl.sv
// Passive car-security controller: IDLE/WARN/ARMING/ARMED/ALARM FSM sharing one cycle counter.
// Optional PASSIVE_SYNC_EN inserts 2-flop input synchronizers ahead of the FSM.
module passive_security_ctrl #(
  parameter int ARM_DELAY  = 8,
  parameter int ALARM_TIME = 16,
  parameter int BUZZ_HALF  = 2,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       CarLightsOnSign,
  input  logic       OpenDoorSign,
  input  logic       IgnitionSignalOn,
  output logic       PassiveSignal_b,
  output logic       PassiveSignal_s,
  output logic [2:0] PassiveState
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WARN   = 3'd1;
  localparam logic [2:0] S_ARMING = 3'd2;
  localparam logic [2:0] S_ARMED  = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;

  localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST  = CNT_W'(ALARM_TIME - 1);
  localparam logic [CNT_W-1:0] BUZZ_HALF_C = CNT_W'(BUZZ_HALF);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO     = CNT_W'(2);

  // Bit order: {ignition, door, lights}
  logic [2:0] raw_in;
  logic [2:0] cond_in;

  assign raw_in = {IgnitionSignalOn, OpenDoorSign, CarLightsOnSign};

`ifdef PASSIVE_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign cond_in = sync2_q;
`else
  assign cond_in = raw_in;
`endif

  logic lights;
  logic door;
  logic ign;

  assign lights = cond_in[0];
  assign door   = cond_in[1];
  assign ign    = cond_in[2];

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter is zeroed on every state change, so no separate clear path is needed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ign) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lights && door) begin
            state_d = S_WARN;
            cnt_d   = '0;
          end else if (!door) begin
            state_d = S_ARMING;
            cnt_d   = '0;
          end
        end
        S_WARN: begin
          if (!lights) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (!door) begin
            state_d = S_ARMING;
            cnt_d   = '0;
          end
        end
        S_ARMING: begin
          if (door) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ARM_LAST) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_ARMED: begin
          if (door) begin
            state_d = S_ALARM;
            cnt_d   = '0;
          end
        end
        S_ALARM: begin
          if (cnt_q == ALARM_LAST) begin
            cnt_d = '0;
            if (!door) state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Buzzer is on during even-numbered BUZZ_HALF windows of the alarm burst.
  logic buzz_on;
  assign buzz_on = ((cnt_q / BUZZ_HALF_C) % CNT_TWO) == '0;

  always_comb begin
    PassiveSignal_b = 1'b0;
    PassiveSignal_s = 1'b0;
    case (state_q)
      S_WARN:  PassiveSignal_b = 1'b1;
      S_ARMED: PassiveSignal_s = 1'b1;
      S_ALARM: begin
        PassiveSignal_b = buzz_on;
        PassiveSignal_s = 1'b1;
      end
      default: begin
        PassiveSignal_b = 1'b0;
        PassiveSignal_s = 1'b0;
      end
    endcase
  end

  assign PassiveState = state_q;

endmodule

// File: tb/tb_passive_security_ctrl.sv
// Scoreboard bench for passive_security_ctrl: stimulus queues expectations, a monitor pops and compares.
module tb_passive_security_ctrl;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       lights = 1'b0;
  logic       door = 1'b0;
  logic       ign = 1'b0;
  logic       sig_b;
  logic       sig_s;
  logic [2:0] state;

  passive_security_ctrl dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .CarLightsOnSign  (lights),
    .OpenDoorSign     (door),
    .IgnitionSignalOn (ign),
    .PassiveSignal_b  (sig_b),
    .PassiveSignal_s  (sig_s),
    .PassiveState     (state)
  );

  always #5 clk = ~clk;

  logic [4:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         failures = 0;
  event       chk_ev;

  task automatic expect_out(input string nm, input logic [2:0] st, input logic b, input logic s);
    exp_q.push_back({st, b, s});
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm, input logic l, input logic d, input logic i,
                      input logic [2:0] st, input logic b, input logic s);
    @(negedge clk);
    lights = l;
    door   = d;
    ign    = i;
    expect_out(nm, st, b, s);
    @(posedge clk);
  endtask

  // Monitor: every posedge (or explicit async event) is a presentation point.
  initial begin
    logic [4:0] e;
    string      nm;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({state, sig_b, sig_s} !== e) begin
          failures++;
          $display("FAIL %s: got state=%0d b=%0b s=%0b, expected state=%0d b=%0b s=%0b",
                   nm, state, sig_b, sig_s, e[4:2], e[1], e[0]);
        end else begin
          $display("ok   %s: state=%0d b=%0b s=%0b", nm, state, sig_b, sig_s);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] buzz_pat;
    buzz_pat = 16'h3333;

    for (int k = 0; k < 3; k++)
      step($sformatf("reset_hold%0d", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;
    step("release_ign0", 1, 1, 1, 3'd0, 0, 0);
    step("release_ign1", 1, 1, 1, 3'd0, 0, 0);

`ifdef PASSIVE_SYNC_EN
    step("sync_warn_e1", 1, 1, 0, 3'd0, 0, 0);
    step("sync_warn_e2", 1, 1, 0, 3'd0, 0, 0);
    step("sync_warn_e3", 1, 1, 0, 3'd1, 1, 0);
    step("sync_off_e1",  0, 1, 0, 3'd1, 1, 0);
    step("sync_off_e2",  0, 1, 0, 3'd1, 1, 0);
    step("sync_off_e3",  0, 1, 0, 3'd0, 0, 0);
`else
    step("warn_enter", 1, 1, 0, 3'd1, 1, 0);
    step("warn_hold",  1, 1, 0, 3'd1, 1, 0);
    step("warn_exit",  0, 1, 0, 3'd0, 0, 0);
    step("idle_door_open", 0, 1, 0, 3'd0, 0, 0);

    for (int k = 1; k <= 4; k++)
      step($sformatf("arm_abort_e%0d", k), 0, 0, 0, 3'd2, 0, 0);
    step("arm_abort_door", 0, 1, 0, 3'd0, 0, 0);

    for (int k = 1; k <= 8; k++)
      step($sformatf("arm_last_e%0d", k), 0, 0, 0, 3'd2, 0, 0);
    step("door_beats_terminal", 0, 1, 0, 3'd0, 0, 0);

    for (int k = 1; k <= 8; k++)
      step($sformatf("arm_e%0d", k), 0, 0, 0, 3'd2, 0, 0);
    step("armed", 0, 0, 0, 3'd3, 0, 1);
    step("armed_lights_ignored", 1, 0, 0, 3'd3, 0, 1);

    step("alarm_cnt0", 0, 1, 0, 3'd4, 1, 1);
    for (int k = 1; k < 16; k++)
      step($sformatf("alarm_cnt%0d", k), 0, 0, 0, 3'd4, buzz_pat[k], 1);
    step("alarm_to_armed", 0, 0, 0, 3'd3, 0, 1);

    step("burst_cnt0", 0, 1, 0, 3'd4, 1, 1);
    for (int k = 1; k < 16; k++)
      step($sformatf("burst_cnt%0d", k), 0, 1, 0, 3'd4, buzz_pat[k], 1);
    step("new_burst_cnt0", 0, 1, 0, 3'd4, 1, 1);
    for (int k = 1; k <= 7; k++)
      step($sformatf("disarm_cnt%0d", k), 0, 0, 0, 3'd4, buzz_pat[k], 1);
    step("disarm_ign", 0, 0, 1, 3'd0, 0, 0);

    for (int k = 1; k <= 8; k++)
      step($sformatf("rearm_e%0d", k), 0, 0, 0, 3'd2, 0, 0);
    step("rearmed", 0, 0, 0, 3'd3, 0, 1);
    step("ign_beats_door", 0, 1, 1, 3'd0, 0, 0);

    for (int k = 1; k <= 8; k++)
      step($sformatf("rearm2_e%0d", k), 0, 0, 0, 3'd2, 0, 0);
    step("rearmed2", 0, 0, 0, 3'd3, 0, 1);
    step("alarm2_cnt0", 0, 1, 0, 3'd4, 1, 1);
    for (int k = 1; k <= 3; k++)
      step($sformatf("alarm2_cnt%0d", k), 0, 0, 0, 3'd4, buzz_pat[k], 1);

    @(negedge clk);
    reset_L = 1'b0;
    expect_out("async_reset", 3'd0, 0, 0);
    -> chk_ev;
    #2;
    step("async_reset_hold", 0, 1, 0, 3'd0, 0, 0);
    @(negedge clk);
    reset_L = 1'b1;
    step("post_reset_idle", 0, 1, 0, 3'd0, 0, 0);
`endif

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
